// File: rtl/duck_pkg.sv
// Shared definitions for the Duck Hunt video path.
// flash_state_t : zapper flash sequencer states.
// COLOR_*       : 6-bit (2 bits per channel) reference colours.
// SCR_*_DEF     : default visible screen size.
package duck_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2,
    HELD  = 2'd3
  } flash_state_t;

  localparam int          COLOR_W_DEF  = 6;
  localparam logic [5:0]  COLOR_BLACK  = 6'b000000;
  localparam logic [5:0]  COLOR_WHITE  = 6'b111111;
  localparam logic [5:0]  COLOR_TARGET = 6'b110000;

  localparam int SCR_W_DEF = 640;
  localparam int SCR_H_DEF = 480;

endpackage

// File: rtl/target_flash_gen_if.sv
// Video/zapper bundle between the timing block, the zapper and the RGB pins.
// master : drives pixel position, frame tick, zapper inputs, background pixel.
// slave  : the target/flash generator consuming them and producing rgb,
//          busy, shot_done and the hit vector.
interface target_flash_gen_if #(
  parameter int N_TARGETS = 2,
  parameter int COLOR_W   = 6
);
  logic                 frame_tick;
  logic                 valid;
  logic [9:0]           col;
  logic [9:0]           row;
  logic                 trigger;
  logic                 light;
  logic [COLOR_W-1:0]   bg_rgb;
  logic [COLOR_W-1:0]   rgb;
  logic                 busy;
  logic                 shot_done;
  logic [N_TARGETS-1:0] hit;

  modport master (
    output frame_tick, valid, col, row, trigger, light, bg_rgb,
    input  rgb, busy, shot_done, hit
  );

  modport slave (
    input  frame_tick, valid, col, row, trigger, light, bg_rgb,
    output rgb, busy, shot_done, hit
  );
endinterface

// File: rtl/target_mover.sv
// Horizontal position of one target box.
// clk, rst_n : pixel clock, async active-low reset (loads x_init)
// tick_en    : advance one STEP this cycle (frame tick while not flashing)
// respawn    : reload x_init (takes priority over tick_en)
// x_init     : start column of this target
// x          : current left column of the box
module target_mover #(
  parameter int SCR_W = 640,
  parameter int BOX_W = 50,
  parameter int STEP  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       respawn,
  input  logic [9:0] x_init,
  output logic [9:0] x
);

  localparam logic [10:0] X_MAX = 11'(SCR_W - BOX_W);

  logic [10:0] x_step;

  // 11-bit sum so the wrap test cannot overflow near the right edge.
  assign x_step = {1'b0, x} + 11'(STEP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= x_init;
    end else if (respawn) begin
      x <= x_init;
    end else if (tick_en) begin
      // Wrap to column 0 rather than letting the box run off screen.
      x <= (x_step > X_MAX) ? 10'd0 : x_step[9:0];
    end
  end

endmodule

// File: rtl/target_flash_gen.sv
// Draws N_TARGETS moving boxes over the sprite background and runs the
// zapper flash sequence (one black frame, then one white frame per target),
// reporting which targets the light sensor saw.
// clk, rst_n : pixel clock, async active-low reset
// bus.slave  : frame_tick/valid/col/row/bg_rgb from video timing,
//              trigger/light from the zapper (already synchronised),
//              rgb (registered, 1-clk latency), busy, shot_done, hit
module target_flash_gen
  import duck_pkg::*;
#(
  parameter int                 N_TARGETS    = 2,
  parameter int                 COLOR_W      = COLOR_W_DEF,
  parameter int                 BOX_W        = 50,
  parameter int                 BOX_H        = 50,
  parameter int                 SCR_W        = SCR_W_DEF,
  parameter int                 SCR_H        = SCR_H_DEF,
  parameter int                 STEP         = 5,
  parameter logic [COLOR_W-1:0] TARGET_COLOR = COLOR_W'(COLOR_TARGET)
) (
  input  logic              clk,
  input  logic              rst_n,
  target_flash_gen_if.slave bus
);

  localparam int KW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

  flash_state_t         state, state_nxt;
  logic [KW-1:0]        k;
  logic                 cheat;
  logic                 trig_q;
  logic [N_TARGETS-1:0] alive;
  logic [N_TARGETS-1:0] flag;
  logic [N_TARGETS-1:0] flag_cur;
  logic [N_TARGETS-1:0] hit_vec;
  logic [N_TARGETS-1:0] in_box;
  logic [9:0]           x [N_TARGETS];
  logic [10:0]          col11, row11;
  logic                 tick, last_k, tick_en, respawn;
  logic [COLOR_W-1:0]   pix;
  logic [COLOR_W-1:0]   rgb_q;
  logic                 shot_done_q;
  logic [N_TARGETS-1:0] hit_q;

  assign tick    = bus.frame_tick;
  assign col11   = {1'b0, bus.col};
  assign row11   = {1'b0, bus.row};
  assign last_k  = (k == KW'(N_TARGETS - 1));
  assign tick_en = tick && ((state == IDLE) || (state == HELD));
  assign respawn = tick && (state == IDLE) && (alive == '0);

  for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_tgt
    localparam logic [9:0]  X_INIT = 10'(gi * ((SCR_W - BOX_W) / N_TARGETS));
    localparam logic [10:0] Y_LO   = 11'(BOX_H + gi * ((SCR_H - 2 * BOX_H) / N_TARGETS));

    logic [10:0] x_lo;

    target_mover #(
      .SCR_W (SCR_W),
      .BOX_W (BOX_W),
      .STEP  (STEP)
    ) u_mover (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_en (tick_en),
      .respawn (respawn),
      .x_init  (X_INIT),
      .x       (x[gi])
    );

    assign x_lo       = {1'b0, x[gi]};
    assign in_box[gi] = alive[gi]
                        && (col11 >= x_lo) && (col11 < x_lo + 11'(BOX_W))
                        && (row11 >= Y_LO) && (row11 < Y_LO + 11'(BOX_H));
  end

  // Light seen this cycle is folded in here so light coincident with the
  // ending frame_tick still counts toward the white frame being closed.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    flag_cur = flag;
    if ((state == WHITE) && bus.light) flag_cur[k] = 1'b1;
  end

  assign hit_vec = flag_cur & alive & {N_TARGETS{~cheat}};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; every transition waits for a frame boundary.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        IDLE:    if (bus.trigger && !trig_q) state_nxt = BLACK;
        BLACK:   state_nxt = WHITE;
        WHITE:   if (last_k) state_nxt = bus.trigger ? HELD : IDLE;
        HELD:    if (!bus.trigger) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: busy flag and pre-register pixel colour.
  always_comb begin
    pix = '0;
    case (state)
      BLACK:   pix = '0;
      WHITE:   pix = in_box[k] ? '1 : '0;
      default: pix = (|in_box) ? TARGET_COLOR : bus.bg_rgb;
    endcase
  end

  assign bus.busy = (state == BLACK) || (state == WHITE);

  // Sequence bookkeeping: trigger history, cheat/light flags, target index,
  // alive mask and the one-cycle shot report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      cheat       <= 1'b0;
      trig_q      <= 1'b0;
      alive       <= '1;
      flag        <= '0;
      shot_done_q <= 1'b0;
      hit_q       <= '0;
    end else begin
      shot_done_q <= 1'b0;
      hit_q       <= '0;
      if (tick) trig_q <= bus.trigger;

      case (state)
        IDLE: begin
          if (tick) begin
            if (alive == '0) alive <= '1;
            if (bus.trigger && !trig_q) begin
              cheat <= 1'b0;
              flag  <= '0;
              k     <= '0;
            end
          end
        end
        BLACK: cheat <= cheat | bus.light;
        WHITE: begin
          flag <= flag_cur;
          if (tick) begin
            if (last_k) begin
              shot_done_q <= 1'b1;
              hit_q       <= hit_vec;
              alive       <= alive & ~hit_vec;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rgb_q <= '0;
    else if (bus.valid) rgb_q <= pix;
    else                rgb_q <= '0;
  end

  assign bus.rgb       = rgb_q;
  assign bus.shot_done = shot_done_q;
  assign bus.hit       = hit_q;

endmodule

// File: tb/tb_target_flash_gen.sv
// Self-checking bench for target_flash_gen (N_TARGETS=2, short frames).
// A frame-level reference model tracks box positions, alive mask, trigger
// history and the light seen in each frame of a shot; every cycle the
// registered pixel, busy, shot_done and hit are compared against it.
module tb_target_flash_gen;
  import duck_pkg::*;

  localparam int N     = 2;
  localparam int CW    = 6;
  localparam int BOX_W = 50;
  localparam int BOX_H = 50;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int STEP  = 5;
  localparam int F     = 16;   // clocks per frame, tick on the last one
  localparam logic [CW-1:0] TGT = COLOR_TARGET;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  target_flash_gen_if #(.N_TARGETS(N), .COLOR_W(CW)) bus ();

  target_flash_gen #(
    .N_TARGETS    (N),
    .COLOR_W      (CW),
    .BOX_W        (BOX_W),
    .BOX_H        (BOX_H),
    .SCR_W        (SCR_W),
    .SCR_H        (SCR_H),
    .STEP         (STEP),
    .TARGET_COLOR (TGT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_shots = 0;
  int busy_cycles = 0;
  logic [N-1:0] last_hit = '0;

  // Reference model (frame granularity).
  int           m_x [N];
  int           m_y [N];
  logic [N-1:0] m_alive;
  int           m_seq;          // 0 = no shot, 1 = black frame, 2.. = white frame for target m_seq-2
  bit           m_held;
  bit           m_trig_q;
  bit           m_lights [N+1]; // light seen in each frame of the shot
  bit           m_fl;           // light seen so far in the current frame
  bit           exp_done;
  logic [N-1:0] exp_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int x_start(input int i);
    return i * ((SCR_W - BOX_W) / N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = x_start(i);
      m_y[i] = BOX_H + i * ((SCR_H - 2 * BOX_H) / N);
    end
    m_alive  = '1;
    m_seq    = 0;
    m_held   = 0;
    m_trig_q = 0;
    m_fl     = 0;
  endtask

  function automatic bit m_box(input int i, input int c, input int r);
    return m_alive[i] && c >= m_x[i] && c < m_x[i] + BOX_W && r >= m_y[i] && r < m_y[i] + BOX_H;
  endfunction

  function automatic logic [CW-1:0] exp_pix(input int c, input int r, input bit v, input logic [CW-1:0] bg);
    bit any;
    any = 0;
    if (!v)        return '0;
    if (m_seq == 1) return '0;
    if (m_seq >= 2) return m_box(m_seq - 2, c, r) ? '1 : '0;
    for (int i = 0; i < N; i++) if (m_box(i, c, r)) any = 1;
    return any ? TGT : bg;
  endfunction

  task automatic model_tick(input bit trig);
    if (m_seq == 0) begin
      if (!m_held && m_alive == '0) begin
        m_alive = '1;
        for (int i = 0; i < N; i++) m_x[i] = x_start(i);
      end else begin
        for (int i = 0; i < N; i++)
          m_x[i] = (m_x[i] + STEP > SCR_W - BOX_W) ? 0 : m_x[i] + STEP;
      end
      if (m_held) begin
        if (!trig) m_held = 0;
      end else if (trig && !m_trig_q) begin
        m_seq = 1;
      end
    end else begin
      m_lights[m_seq - 1] = m_fl;
      if (m_seq == N + 1) begin
        for (int i = 0; i < N; i++)
          exp_hit[i] = m_lights[i + 1] && m_alive[i] && !m_lights[0];
        exp_done = 1;
        m_alive  = m_alive & ~exp_hit;
        m_held   = trig;
        m_seq    = 0;
      end else begin
        m_seq++;
      end
    end
    m_trig_q = trig;
    m_fl     = 0;
  endtask

  task automatic gen_pos(output int c, output int r);
    int t;
    if ($urandom_range(0, 1) == 1) begin
      t = int'($urandom_range(0, N - 1));
      c = m_x[t] + int'($urandom_range(0, BOX_W + 5)) - 3;
      r = m_y[t] + int'($urandom_range(0, BOX_H + 5)) - 3;
      if (c < 0) c = 0;
      if (r < 0) r = 0;
    end else begin
      c = int'($urandom_range(0, 700));
      r = int'($urandom_range(0, 500));
    end
  endtask

  task automatic do_cycle(input bit tick, input bit trig, input bit light,
                          input int c, input int r, input bit v, input logic [CW-1:0] bg);
    logic [CW-1:0] ep;
    @(negedge clk);
    bus.frame_tick = tick;
    bus.trigger    = trig;
    bus.light      = light;
    bus.col        = 10'(c);
    bus.row        = 10'(r);
    bus.valid      = v;
    bus.bg_rgb     = bg;
    ep = exp_pix(c, r, v, bg);
    @(posedge clk);
    #1;
    check("rgb", 32'(bus.rgb), 32'(ep));
    m_fl     = m_fl | light;
    exp_done = 0;
    exp_hit  = '0;
    if (tick) model_tick(trig);
    check("busy", 32'(bus.busy), 32'(m_seq != 0));
    check("shot_done", 32'(bus.shot_done), 32'(exp_done));
    check("hit", 32'(bus.hit), 32'(exp_hit));
    if (bus.busy) busy_cycles++;
    if (bus.shot_done) begin
      dut_shots++;
      last_hit = bus.hit;
    end
  endtask

  // lmode: 0 dark, 1 sparse random flashes, 2 light every cycle, 3 light only on the tick cycle
  task automatic run_frame(input bit trig, input int lmode);
    int c, r;
    bit tk, lt;
    for (int cyc = 0; cyc < F; cyc++) begin
      tk = (cyc == F - 1);
      case (lmode)
        1:       lt = ($urandom_range(0, 7) == 0);
        2:       lt = 1;
        3:       lt = tk;
        default: lt = 0;
      endcase
      gen_pos(c, r);
      do_cycle(tk, trig, lt, c, r, $urandom_range(0, 7) != 0, CW'($urandom));
    end
  endtask

  task automatic probe(input string tag, input int c, input int r, input logic [CW-1:0] want);
    do_cycle(0, 0, 0, c, r, 1, 6'b001010);
    check(tag, 32'(bus.rgb), 32'(want));
  endtask

  initial begin
    int shots0;
    int c, r;

    bus.frame_tick = 0;
    bus.trigger    = 0;
    bus.light      = 0;
    bus.col        = '0;
    bus.row        = '0;
    bus.valid      = 0;
    bus.bg_rgb     = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'(bus.rgb), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_shot_done", 32'(bus.shot_done), 32'(0));
    check("reset_hit", 32'(bus.hit), 32'(0));
    @(negedge clk);
    rst_n = 1;

    // Motion with no trigger, long enough for target 0 to wrap past 585
    repeat (125) run_frame(0, 1);

    // Hit target 1: light at the IDLE->BLACK tick must not count as cheat;
    // trigger rising mid-shot must be ignored; light only on the closing tick of white k=1
    run_frame(1, 3);
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 3);
    check("hit_target1", 32'(last_hit), 32'(2'b10));
    check("shots_after_hit1", 32'(dut_shots), 32'(1));
    repeat (2) run_frame(0, 1);

    // Cheat: light through black and both white frames
    run_frame(1, 0);
    run_frame(1, 2);
    run_frame(1, 2);
    run_frame(0, 2);
    check("cheat_hit", 32'(last_hit), 32'(2'b00));
    check("shots_after_cheat", 32'(dut_shots), 32'(2));
    run_frame(0, 0);

    // Hold trigger 10 frames: one shot only
    busy_cycles = 0;
    repeat (10) run_frame(1, 0);
    check("hold_busy_cycles", 32'(busy_cycles), 32'(3 * F));
    check("hold_shots", 32'(dut_shots), 32'(3));
    run_frame(0, 0);
    run_frame(1, 0);
    check("refire_busy", 32'(bus.busy), 32'(1));
    repeat (3) run_frame(0, 0);
    check("refire_shots", 32'(dut_shots), 32'(4));

    // Kill target 0 (target 1 already dead), then respawn on the next IDLE tick
    run_frame(1, 0);
    run_frame(0, 0);
    run_frame(0, 2);
    run_frame(0, 0);
    check("kill_target0", 32'(last_hit), 32'(2'b01));
    run_frame(0, 1);
    probe("respawn_x0_left", 0, 50, TGT);
    probe("respawn_x0_right_excl", 50, 50, 6'b001010);
    probe("respawn_x1_left", 295, 240, TGT);
    probe("respawn_x1_right_excl", 345, 240, 6'b001010);
    do_cycle(0, 0, 0, 10, 60, 0, 6'b111111);
    check("valid_low_black", 32'(bus.rgb), 32'(0));

    // Reset in the middle of the first white frame
    shots0 = dut_shots;
    run_frame(1, 0);
    run_frame(0, 1);
    for (int i = 0; i < 8; i++) begin
      gen_pos(c, r);
      do_cycle(0, 0, $urandom_range(0, 1) == 1, c, r, 1, CW'($urandom));
    end
    @(negedge clk);
    bus.frame_tick = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("midreset_busy", 32'(bus.busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midreset_rgb", 32'(bus.rgb), 32'(0));
      check("midreset_shot_done", 32'(bus.shot_done), 32'(0));
      check("midreset_hit", 32'(bus.hit), 32'(0));
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) run_frame(0, 1);
    check("midreset_no_shot", 32'(dut_shots), 32'(shots0));

    // Randomised shots against the model
    repeat (60) run_frame($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
